// File: rtl/signnarrower_r0.sv
// rtl/signnarrower_r0.sv - per-lane wide-to-narrow converter with clamp/wrap and a 2-entry skid buffer
module signnarrower_r0 #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int DEPTH     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_n,
    input  logic [DEPTH*IN_WIDTH-1:0]     dataIn,
    input  logic                          isSigned,
    input  logic                          saturate,
    input  logic                          inValid,
    output logic                          inReady,
    output logic [DEPTH*OUT_WIDTH-1:0]    dataOut,
    output logic [DEPTH-1:0]              ovf,
    output logic                          outValid,
    input  logic                          outReady,
    input  logic                          ovfClr,
    output logic [15:0]                   ovfCount
);

    localparam int DROP = IN_WIDTH - OUT_WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } bufState_e;

    bufState_e state;
    bufState_e stateNext;

    logic [DEPTH*OUT_WIDTH-1:0] narrowData;
    logic [DEPTH-1:0]           narrowOvf;

    logic [DEPTH*OUT_WIDTH-1:0] headData;
    logic [DEPTH-1:0]           headOvf;
    logic [DEPTH*OUT_WIDTH-1:0] tailData;
    logic [DEPTH-1:0]           tailOvf;

    logic inReadyReg;
    logic outValidReg;
    logic [15:0] ovfCountReg;

    logic accept;
    logic deliver;
    logic loadHead;
    logic loadTail;
    logic shiftTail;

    // Narrowing is purely combinational; the result is captured at acceptance.
    for (genvar i = 0; i < DEPTH; i++) begin : gLane
        logic [IN_WIDTH-1:0]  lane;
        logic [DROP-1:0]      dropped;
        logic                 unsOvf;
        logic                 signOvf;
        logic                 laneOvf;
        logic [OUT_WIDTH-1:0] satVal;

        assign lane    = dataIn[IN_WIDTH*i +: IN_WIDTH];
        assign dropped = lane[IN_WIDTH-1:OUT_WIDTH];
        assign unsOvf  = |dropped;
        // Signed value fits only when the dropped bits replicate the new sign bit.
        assign signOvf = !((&{dropped, lane[OUT_WIDTH-1]}) || !(|{dropped, lane[OUT_WIDTH-1]}));
        assign laneOvf = isSigned ? signOvf : unsOvf;

        always_comb begin
            satVal = '1;
            if (isSigned) begin
                if (lane[IN_WIDTH-1]) begin
                    satVal = {1'b1, {(OUT_WIDTH-1){1'b0}}};
                end else begin
                    satVal = {1'b0, {(OUT_WIDTH-1){1'b1}}};
                end
            end
        end

        assign narrowData[OUT_WIDTH*i +: OUT_WIDTH] = (saturate && laneOvf) ? satVal : lane[OUT_WIDTH-1:0];
        assign narrowOvf[i] = laneOvf;
    end

    assign accept  = inValid && inReadyReg && !en_n;
    assign deliver = outValidReg && outReady && !en_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        loadHead  = 1'b0;
        loadTail  = 1'b0;
        shiftTail = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    stateNext = ONE;
                    loadHead  = 1'b1;
                end
            end
            ONE: begin
                if (accept && !deliver) begin
                    stateNext = TWO;
                    loadTail  = 1'b1;
                end else if (accept && deliver) begin
                    loadHead  = 1'b1;
                end else if (deliver) begin
                    stateNext = EMPTY;
                end
            end
            TWO: begin
                if (deliver) begin
                    stateNext = ONE;
                    shiftTail = 1'b1;
                end
            end
            default: begin
                stateNext = EMPTY;
            end
        endcase
    end

    // Handshake flags are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            inReadyReg  <= 1'b1;
            outValidReg <= 1'b0;
        end else begin
            inReadyReg  <= (stateNext != TWO);
            outValidReg <= (stateNext != EMPTY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            headData <= '0;
            headOvf  <= '0;
            tailData <= '0;
            tailOvf  <= '0;
        end else begin
            if (loadHead) begin
                headData <= narrowData;
                headOvf  <= narrowOvf;
            end else if (shiftTail) begin
                headData <= tailData;
                headOvf  <= tailOvf;
            end
            if (loadTail) begin
                tailData <= narrowData;
                tailOvf  <= narrowOvf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovfCountReg <= '0;
        end else if (!en_n) begin
            if (ovfClr) begin
                ovfCountReg <= '0;
            end else if (accept && (|narrowOvf) && (ovfCountReg != 16'hFFFF)) begin
                ovfCountReg <= ovfCountReg + 16'd1;
            end
        end
    end

    assign inReady  = inReadyReg;
    assign outValid = outValidReg;
    assign dataOut  = headData;
    assign ovf      = headOvf;
    assign ovfCount = ovfCountReg;

endmodule

// File: tb/tb_signnarrower_r0.sv
// tb/tb_signnarrower_r0.sv - randomized and directed bench for signnarrower_r0 against a queue-based reference
module tb_signnarrower_r0;

    localparam int IW = 32;
    localparam int OW = 16;
    localparam int D  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, en_n, isSigned, saturate, inValid, inReady;
    logic            outValid, outReady, ovfClr;
    logic [D*IW-1:0] dataIn;
    logic [D*OW-1:0] dataOut;
    logic [D-1:0]    ovf;
    logic [15:0]     ovfCount;

    signnarrower_r0 #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .en_n(en_n), .dataIn(dataIn), .isSigned(isSigned),
        .saturate(saturate), .inValid(inValid), .inReady(inReady), .dataOut(dataOut),
        .ovf(ovf), .outValid(outValid), .outReady(outReady), .ovfClr(ovfClr),
        .ovfCount(ovfCount)
    );

    typedef struct {
        logic [D*OW-1:0] data;
        logic [D-1:0]    ovf;
    } beat_t;

    beat_t modelQ[$];
    int    modelCnt;
    int    checks   = 0;
    int    failures = 0;

    logic [IW-1:0] edgeVals [8] = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_7FFF,
                                    32'h0000_FFFF, 32'h0001_0000, 32'h0000_0000, 32'hFFFF_FFFF};

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: treat each lane as an integer and test it against the target range.
    function automatic beat_t refBeat(input logic [D*IW-1:0] din, input bit sgn, input bit sat);
        beat_t         b;
        longint        v, lo, hi;
        logic [IW-1:0] x;
        for (int i = 0; i < D; i++) begin
            x = din[i*IW +: IW];
            if (sgn) begin
                v  = $signed(x);
                lo = -(longint'(1) << (OW-1));
                hi = (longint'(1) << (OW-1)) - 1;
            end else begin
                v  = x;
                lo = 0;
                hi = (longint'(1) << OW) - 1;
            end
            b.ovf[i] = (v < lo) || (v > hi);
            if (b.ovf[i] && sat) begin
                b.data[i*OW +: OW] = (v < lo) ? OW'(lo) : OW'(hi);
            end else begin
                b.data[i*OW +: OW] = x[OW-1:0];
            end
        end
        return b;
    endfunction

    task automatic step(input bit r, input bit enN, input bit iv, input bit ordy,
                        input bit sgn, input bit sat, input bit clr, input logic [D*IW-1:0] din);
        bit    acc, del;
        beat_t b;
        @(negedge clk);
        rst = r; en_n = enN; inValid = iv; outReady = ordy;
        isSigned = sgn; saturate = sat; ovfClr = clr; dataIn = din;
        #1;
        checkVal("inReady", inReady, modelQ.size() < 2);
        checkVal("outValid", outValid, modelQ.size() > 0);
        checkVal("ovfCount", ovfCount, modelCnt);
        if (modelQ.size() > 0) begin
            checkVal("dataOut", dataOut, modelQ[0].data);
            checkVal("ovf", ovf, modelQ[0].ovf);
        end
        b   = refBeat(din, sgn, sat);
        acc = !enN && iv && (modelQ.size() < 2);
        del = !enN && ordy && (modelQ.size() > 0);
        if (r) begin
            modelQ.delete();
            modelCnt = 0;
        end else if (!enN) begin
            if (del) void'(modelQ.pop_front());
            if (acc) modelQ.push_back(b);
            if (clr) modelCnt = 0;
            else if (acc && (|b.ovf) && modelCnt < 65535) modelCnt++;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0, 0, '0);
    endtask

    function automatic logic [D*IW-1:0] dup(input logic [IW-1:0] x);
        return {D{x}};
    endfunction

    function automatic logic [IW-1:0] randLane();
        logic [15:0] s;
        case ($urandom_range(0, 2))
            0: return IW'($urandom);
            1: begin
                s = 16'($urandom);
                return {{(IW-16){s[15]}}, s} + IW'($urandom_range(0, 2)) - IW'(1);
            end
            default: return edgeVals[$urandom_range(0, 7)];
        endcase
    endfunction

    logic [D*OW-1:0] snapData;
    logic [D-1:0]    snapOvf;
    logic [15:0]     snapCnt;
    logic [D*IW-1:0] rdin;

    initial begin
        rst = 1'b1; en_n = 1'b1; inValid = 1'b0; outReady = 1'b0;
        isSigned = 1'b0; saturate = 1'b0; ovfClr = 1'b0; dataIn = '0;
        modelCnt = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checkVal("rst_outValid", outValid, 1'b0);
        checkVal("rst_inReady", inReady, 1'b1);
        checkVal("rst_dataOut", dataOut, '0);
        checkVal("rst_ovf", ovf, '0);
        checkVal("rst_ovfCount", ovfCount, 16'h0);

        // Unsigned clamp, one-cycle latency
        step(0, 0, 1, 1, 0, 1, 0, dup(32'h0001_2345));
        checkVal("u_sat_valid", outValid, 1'b1);
        checkVal("u_sat_data", dataOut[15:0], 16'hFFFF);
        checkVal("u_sat_ovf", ovf[0], 1'b1);
        checkVal("u_sat_cnt", ovfCount, 16'd1);
        idle(1);

        // Signed clamp
        step(0, 0, 1, 1, 1, 1, 0, dup(32'hFFFF_7000));
        checkVal("s_min_data", dataOut[15:0], 16'h8000);
        checkVal("s_min_ovf", ovf[0], 1'b1);
        step(0, 0, 1, 1, 1, 1, 0, dup(32'h0000_8000));
        checkVal("s_max_data", dataOut[15:0], 16'h7FFF);
        checkVal("s_max_ovf", ovf[0], 1'b1);
        step(0, 0, 1, 1, 1, 1, 0, dup(32'hFFFF_8000));
        checkVal("s_edge_data", dataOut[15:0], 16'h8000);
        checkVal("s_edge_ovf", ovf[0], 1'b0);

        // Wrap mode and in-range unsigned
        step(0, 0, 1, 1, 1, 0, 0, dup(32'h0001_8001));
        checkVal("s_wrap_data", dataOut[15:0], 16'h8001);
        checkVal("s_wrap_ovf", ovf[0], 1'b1);
        step(0, 0, 1, 1, 0, 1, 0, dup(32'h0000_ABCD));
        checkVal("u_fit_data", dataOut[15:0], 16'hABCD);
        checkVal("u_fit_ovf", ovf[0], 1'b0);
        idle(2);

        // Backpressure
        step(0, 0, 1, 0, 0, 0, 0, dup(32'h11));
        checkVal("bp_rdyA", inReady, 1'b1);
        step(0, 0, 1, 0, 0, 0, 0, dup(32'h22));
        checkVal("bp_rdyB", inReady, 1'b0);
        checkVal("bp_headB", dataOut[15:0], 16'h0011);
        step(0, 0, 1, 0, 0, 0, 0, dup(32'h33));
        checkVal("bp_stall", dataOut[15:0], 16'h0011);
        step(0, 0, 1, 1, 0, 0, 0, dup(32'h33));
        checkVal("bp_secB", dataOut[15:0], 16'h0022);
        checkVal("bp_rdyC", inReady, 1'b1);
        step(0, 0, 1, 1, 0, 0, 0, dup(32'h33));
        checkVal("bp_thirdC", dataOut[15:0], 16'h0033);
        step(0, 0, 0, 1, 0, 0, 0, '0);
        checkVal("bp_drained", outValid, 1'b0);

        // Counter saturation and clear priority
        step(1, 0, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 65535; i++) step(0, 0, 1, 1, 0, 1, 0, dup(32'hFFFF_FFFF));
        checkVal("cnt_full", ovfCount, 16'hFFFF);
        step(0, 0, 1, 1, 0, 1, 0, dup(32'hFFFF_FFFF));
        checkVal("cnt_hold", ovfCount, 16'hFFFF);
        step(0, 0, 1, 1, 0, 1, 1, dup(32'hFFFF_FFFF));
        checkVal("cnt_clr", ovfCount, 16'h0);
        idle(2);

        // Reset while full
        step(0, 0, 1, 0, 0, 1, 0, dup(32'h0005_0000));
        step(0, 0, 1, 0, 0, 1, 0, dup(32'h0006_0000));
        checkVal("two_full", inReady, 1'b0);
        step(1, 0, 1, 1, 0, 1, 0, dup(32'h0007_0000));
        checkVal("rst2_outValid", outValid, 1'b0);
        checkVal("rst2_inReady", inReady, 1'b1);
        checkVal("rst2_cnt", ovfCount, 16'h0);
        checkVal("rst2_data", dataOut, '0);

        // Enable freeze
        step(0, 0, 1, 0, 1, 1, 0, dup(32'h0000_9000));
        snapData = dataOut; snapOvf = ovf; snapCnt = ovfCount;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 1, 0, 1, 1, dup(32'hFFFF_FFFF));
            checkVal("frz_data", dataOut, snapData);
            checkVal("frz_ovf", ovf, snapOvf);
            checkVal("frz_cnt", ovfCount, snapCnt);
            checkVal("frz_valid", outValid, 1'b1);
            checkVal("frz_ready", inReady, 1'b1);
        end
        idle(2);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            for (int l = 0; l < D; l++) rdin[l*IW +: IW] = randLane();
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 1'($urandom), 1'($urandom), $urandom_range(0, 49) == 0, rdin);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signnarrower_r0.md
SIGNNARROWER_R0 -- requirements
Module: signnarrower_r0

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, meaning the width of each wide input lane.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, meaning the width of each narrow output lane; OUT_WIDTH < IN_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 1, meaning the number of packed lanes per beat; lane i occupies bits [W*i+W-1 : W*i].
REQ-004 SHALL have port clk  input  1  rising-edge clock; the block uses one clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port en_n  input  1  active-low enable; when 1, all state and outputs hold.
REQ-007 SHALL have port dataIn  input  DEPTH*IN_WIDTH  packed wide lanes.
REQ-008 SHALL have port isSigned  input  1  1 = two's-complement lanes, 0 = unsigned lanes; sampled with the beat.
REQ-009 SHALL have port saturate  input  1  1 = clamp on overflow, 0 = truncate (wrap); sampled with the beat.
REQ-010 SHALL have port inValid  input  1  upstream beat valid.
REQ-011 SHALL have port inReady  output  1  block can accept a beat.
REQ-012 SHALL have port dataOut  output  DEPTH*OUT_WIDTH  packed narrowed lanes.
REQ-013 SHALL have port ovf  output  DEPTH  per-lane overflow flag, aligned with dataOut.
REQ-014 SHALL have port outValid  output  1  dataOut/ovf valid.
REQ-015 SHALL have port outReady  input  1  downstream accepts the beat.
REQ-016 SHALL have port ovfClr  input  1  synchronous clear of ovfCount.
REQ-017 SHALL have port ovfCount  output  16  count of accepted input beats with any lane overflowing.

Function
REQ-018 SHALL accept an input beat when inValid & inReady & !en_n, and deliver an output beat when outValid & outReady & !en_n.
REQ-019 SHALL compute the narrowed result at input acceptance and register it; latency is 1 cycle from acceptance to outValid when the buffer was empty.
REQ-020 SHALL use a 2-entry skid buffer with states EMPTY, ONE, TWO; inReady = 1 in EMPTY and ONE, 0 in TWO, driven from a register.
REQ-021 Transitions: EMPTY -accept-> ONE; ONE -accept&!deliver-> TWO; ONE -deliver&!accept-> EMPTY; ONE -accept&deliver-> ONE; TWO -deliver-> ONE; all other cases hold.
REQ-022 SHALL deliver beats in acceptance order, with no loss or duplication; in TWO, dataOut shows the older entry.
REQ-023 SHALL keep dataOut and ovf stable while outValid=1 and outReady=0.
REQ-024 Unsigned overflow: any of the dropped bits [IN_WIDTH-1:OUT_WIDTH] is 1; saturated result = all ones.
REQ-025 Signed overflow: the dropped bits plus bit OUT_WIDTH-1 are not all equal; saturated result = 0 followed by ones (max) if input MSB=0, else 1 followed by zeros (min).
REQ-026 With saturate=0, the result SHALL be the low OUT_WIDTH bits; ovf SHALL still be reported.
REQ-027 The result SHALL equal the low OUT_WIDTH bits whenever the lane does not overflow, regardless of saturate.
REQ-028 ovfCount SHALL increment by 1 per accepted beat with any ovf bit set and saturate at 0xFFFF.
REQ-029 ovfClr SHALL take priority over a simultaneous increment; the result is 0.
REQ-030 en_n=1 SHALL freeze state, buffer contents, and ovfCount, and SHALL block ovfClr; outputs hold their values.

Reset
REQ-031 rst=1 at a clock edge SHALL force state EMPTY, outValid=0, inReady=1, dataOut=0, ovf=0, ovfCount=0, regardless of en_n.
REQ-032 Reset during operation SHALL discard buffered beats; no beat is delivered after reset from data accepted before it.

Verification
REQ-033 Unsigned, sat=1, dataIn=0x0001_2345, outReady=1 -> dataOut=0xFFFF, ovf=1, one cycle later; ovfCount=1.
REQ-034 Signed, sat=1: 0xFFFF_7000 -> 0x8000, ovf=1; 0x0000_8000 -> 0x7FFF, ovf=1; 0xFFFF_8000 -> 0x8000, ovf=0.
REQ-035 Signed, sat=0, 0x0001_8001 -> 0x8001, ovf=1; unsigned 0x0000_ABCD -> 0xABCD, ovf=0.
REQ-036 Backpressure: outReady=0, send 3 beats A,B,C -> A,B accepted, inReady=0 after B; raise outReady -> A,B,C delivered in order, dataOut held while stalled.
REQ-037 Counter: preload ovfCount to 0xFFFF, send an overflowing beat -> stays 0xFFFF; ovfClr with an overflowing beat in the same cycle -> 0.
REQ-038 Reset in state TWO -> next cycle outValid=0, inReady=1, ovfCount=0; en_n=1 for 5 cycles with traffic -> no state change.
